decode_stage: RTL
=================

Name: decode_stage

Overview:
- Parametrised, registered instruction-decode pipeline stage for the processor datapath.
- Takes raw instruction words over a valid/ready handshake and splits them into opcode, register addresses, shift amount, extended immediate and jump address. Adds an instruction-class tag and an illegal-opcode flag.
- Has a 2-entry skid buffer, so it sustains one instruction per clock under backpressure. Sits between instruction fetch and register-file read / ALU control.

Parameters:
- IW, 16, instruction width in bits.
- OPW, 4, opcode width; opcode = instr[OPW-1:0].
- RAW, 3, register-address width.
- ADW, 9, jump address width; addr = instr[OPW+ADW-1:OPW]. Requires OPW+ADW <= IW.
- R_MASK, 16'h001F, bit n set means opcode n is R-type. Width is 2^OPW.
- I_MASK, 16'hC1E0, bit n set means opcode n is I-type.
- J_MASK, 16'h0200, bit n set means opcode n is J-type.
- SEXT_IMM, 1, 1 = sign-extend the immediate to IW bits; 0 = zero-extend.
- CNTW, 8, illegal-opcode counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  instruction word valid.
- in_ready  out  1  stage can accept a word.
- in_instr  in  IW  raw instruction.
- out_valid  out  1  decoded entry valid.
- out_ready  in  1  consumer accepts the entry.
- out_opcode  out  OPW  opcode field.
- out_class  out  2  00 illegal, 01 R, 10 I, 11 J.
- out_illegal  out  1  opcode matched no class mask.
- out_dest  out  RAW  destination register.
- out_op1  out  RAW  source 1 register.
- out_op2  out  RAW  source 2 register.
- out_shamt  out  IW-OPW-3*RAW  shift amount.
- out_imm  out  IW  extended immediate.
- out_addr  out  ADW  jump address.
- illegal_cnt  out  CNTW  saturating count of accepted illegal words.

Behaviour:
- Field map:
  - dest = instr[OPW+RAW-1:OPW]
  - op1 = next RAW bits
  - op2 = next RAW bits
  - shamt = remaining upper bits
  - const = instr[IW-1:OPW+2*RAW]
  - Defaults give opcode[3:0], dest[6:4], op1[9:7], op2[12:10], shamt[15:13], const[15:10], addr[12:4].
- Class priority when masks overlap: R, then I, then J. No mask hit means illegal: class 00, out_illegal=1.
- Fields unused by the class are driven to zero, never held from a prior instruction:
  - R: imm=0, addr=0.
  - I: op2=0, shamt=0, addr=0.
  - J: dest=0, op1=0, op2=0, shamt=0, imm=0.
  - Illegal: all fields 0 except opcode.
- Decode is computed combinationally on in_instr and stored with each entry.
- Latency: an accepted word appears on out_* the next cycle when the output register is empty or draining.
- Storage: output register (main) plus one skid register.
- Accept condition: in_valid && in_ready.
- in_ready is a register; it is 1 exactly when the skid register is empty.
- Per cycle, with drain = out_valid && out_ready:
  - Main empty or draining, skid empty: an accepted word loads main.
  - Main full and not draining: an accepted word loads skid; in_ready falls next cycle.
  - Draining with skid full: skid moves to main, skid empties, in_ready rises next cycle.
- Order is strictly FIFO. No entry is dropped or duplicated.
- out_* are stable while out_valid && !out_ready.
- flush: next cycle out_valid=0, skid empty, in_ready=1. Flush wins over a same-cycle accept; that word is discarded and not counted. Flush does not clear illegal_cnt.
- illegal_cnt increments by 1 on each accepted illegal word. It saturates at 2^CNTW-1.
- reset: synchronous and overrides flush. Reset values:
  - out_valid=0, in_ready=1, skid empty, illegal_cnt=0.
  - out_opcode, out_class, out_illegal, out_dest, out_op1, out_op2, out_shamt, out_imm, out_addr all 0.
- Reset mid-stream discards all buffered entries.

Test Plan:
- Reset, then 16'h2AB1 with out_ready=1 → next cycle: class 01, opcode 1, dest 3, op1 5, op2 2, shamt 1, imm 0, addr 0, illegal 0.
- 16'hF8A5, SEXT_IMM=1 → class 10, opcode 5, dest 2, op1 1, imm 16'hFFFE, op2 0, shamt 0. With SEXT_IMM=0, imm is 16'h003E.
- 16'h1559 → class 11, opcode 9, addr 9'h155, all register fields 0. Then 16'h000A → class 00, out_illegal=1, illegal_cnt=1.
- Backpressure: stream 0x2AB1, 0xF8A5, 0x1559 back-to-back while out_ready=0.
  - After two accepts, in_ready=0 and the third word is held by the source.
  - Raise out_ready: outputs appear in order one per cycle, none lost. in_ready returns to 1 one cycle after the skid drains.
- Flush with both entries full and in_valid=1 on the same cycle → next cycle out_valid=0, in_ready=1. illegal_cnt is unchanged, including when the flushed input word is illegal.
- CNTW=2: accept five 16'h000B words → illegal_cnt goes 1,2,3,3,3. Then reset → illegal_cnt=0, out_valid=0.

Source files
------------

// File: rtl/decode_stage.sv
`timescale 1ns/1ps
// decode_stage: registered instruction-decode pipeline stage.
// Splits a raw instruction word into opcode, register addresses, shift
// amount, extended immediate and jump address, tags it with an instruction
// class and an illegal flag, and buffers up to two decoded entries (output
// register plus skid register) so a full-rate stream survives backpressure.
//
// Ports:
//   clk, reset (sync, active-high), flush (sync discard of buffered entries)
//   in_valid / in_ready / in_instr        : upstream handshake and raw word
//   out_valid / out_ready                 : downstream handshake
//   out_opcode, out_class, out_illegal    : decode tag
//   out_dest, out_op1, out_op2, out_shamt : register-format fields
//   out_imm, out_addr                     : extended immediate, jump address
//   illegal_cnt                           : saturating count of accepted illegal words
module decode_stage #(
    parameter int               IW       = 16,
    parameter int               OPW      = 4,
    parameter int               RAW      = 3,
    parameter int               ADW      = 9,
    parameter logic [2**OPW-1:0] R_MASK  = 16'h001F,
    parameter logic [2**OPW-1:0] I_MASK  = 16'hC1E0,
    parameter logic [2**OPW-1:0] J_MASK  = 16'h0200,
    parameter bit               SEXT_IMM = 1'b1,
    parameter int               CNTW     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IW-1:0]           in_instr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OPW-1:0]          out_opcode,
    output logic [1:0]              out_class,
    output logic                    out_illegal,
    output logic [RAW-1:0]          out_dest,
    output logic [RAW-1:0]          out_op1,
    output logic [RAW-1:0]          out_op2,
    output logic [IW-OPW-3*RAW-1:0] out_shamt,
    output logic [IW-1:0]           out_imm,
    output logic [ADW-1:0]          out_addr,
    output logic [CNTW-1:0]         illegal_cnt
);

    localparam int SHW = IW - OPW - 3 * RAW;            // shift-amount width
    localparam int CW  = IW - OPW - 2 * RAW;            // raw constant width
    localparam int EW  = OPW + 3 + 3 * RAW + SHW + IW + ADW;
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    localparam logic [1:0] CLASS_ILL = 2'b00;
    localparam logic [1:0] CLASS_R   = 2'b01;
    localparam logic [1:0] CLASS_I   = 2'b10;
    localparam logic [1:0] CLASS_J   = 2'b11;

    logic [OPW-1:0] dec_opcode_s;
    logic [1:0]     dec_class_s;
    logic           dec_illegal_s;
    logic [RAW-1:0] dec_dest_s, dec_op1_s, dec_op2_s;
    logic [SHW-1:0] dec_shamt_s;
    logic [IW-1:0]  dec_imm_s;
    logic [ADW-1:0] dec_addr_s;
    logic [CW-1:0]  const_s;
    logic [IW-1:0]  imm_ext_s;
    logic [EW-1:0]  dec_entry_s;

    logic [EW-1:0]   main_d, main_q;
    logic [EW-1:0]   skid_d, skid_q;
    logic            out_valid_d, out_valid_q;
    logic            in_ready_d, in_ready_q;   // low exactly while the skid register holds an entry
    logic [CNTW-1:0] illegal_cnt_d, illegal_cnt_q;
    logic            accept_s, drain_s;

    // Field extraction, immediate extension and class decode of the incoming word.
    always_comb begin
        const_s = in_instr[IW-1:OPW+2*RAW];
        if (SEXT_IMM) begin
            imm_ext_s = {{(IW-CW){const_s[CW-1]}}, const_s};
        end else begin
            imm_ext_s = {{(IW-CW){1'b0}}, const_s};
        end

        dec_opcode_s  = in_instr[OPW-1:0];
        dec_class_s   = CLASS_ILL;
        dec_illegal_s = 1'b0;
        dec_dest_s    = '0;
        dec_op1_s     = '0;
        dec_op2_s     = '0;
        dec_shamt_s   = '0;
        dec_imm_s     = '0;
        dec_addr_s    = '0;

        // Overlapping masks resolve R before I before J; fields a class
        // does not use stay zero so nothing leaks from an earlier word.
        if (R_MASK[dec_opcode_s]) begin
            dec_class_s = CLASS_R;
            dec_dest_s  = in_instr[OPW+RAW-1:OPW];
            dec_op1_s   = in_instr[OPW+2*RAW-1:OPW+RAW];
            dec_op2_s   = in_instr[OPW+3*RAW-1:OPW+2*RAW];
            dec_shamt_s = in_instr[IW-1:OPW+3*RAW];
        end else if (I_MASK[dec_opcode_s]) begin
            dec_class_s = CLASS_I;
            dec_dest_s  = in_instr[OPW+RAW-1:OPW];
            dec_op1_s   = in_instr[OPW+2*RAW-1:OPW+RAW];
            dec_imm_s   = imm_ext_s;
        end else if (J_MASK[dec_opcode_s]) begin
            dec_class_s = CLASS_J;
            dec_addr_s  = in_instr[OPW+ADW-1:OPW];
        end else begin
            dec_class_s   = CLASS_ILL;
            dec_illegal_s = 1'b1;
        end

        dec_entry_s = {dec_opcode_s, dec_class_s, dec_illegal_s, dec_dest_s, dec_op1_s,
                       dec_op2_s, dec_shamt_s, dec_imm_s, dec_addr_s};
    end

    // Buffer control: output register, skid register, ready and illegal counter.
    always_comb begin
        main_d        = main_q;
        skid_d        = skid_q;
        out_valid_d   = out_valid_q;
        in_ready_d    = in_ready_q;
        illegal_cnt_d = illegal_cnt_q;
        accept_s      = in_valid && in_ready_q;
        drain_s       = out_valid_q && out_ready;

        if (flush) begin
            // Flush discards both entries and any same-cycle word; the
            // counter is deliberately left alone.
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
        end else begin
            if (!in_ready_q) begin
                // Skid full (main is necessarily full): only a drain moves data.
                if (drain_s) begin
                    main_d     = skid_q;
                    in_ready_d = 1'b1;
                end else begin
                    main_d     = main_q;
                end
            end else if (accept_s) begin
                if (!out_valid_q || drain_s) begin
                    main_d      = dec_entry_s;
                    out_valid_d = 1'b1;
                end else begin
                    skid_d     = dec_entry_s;
                    in_ready_d = 1'b0;
                end
            end else if (drain_s) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end

            if (accept_s && dec_illegal_s && (illegal_cnt_q != CNT_MAX)) begin
                illegal_cnt_d = illegal_cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
            end else begin
                illegal_cnt_d = illegal_cnt_q;
            end
        end
    end

    // State registers; reset overrides flush and clears every output.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_q        <= '0;
            skid_q        <= '0;
            out_valid_q   <= 1'b0;
            in_ready_q    <= 1'b1;
            illegal_cnt_q <= '0;
        end else begin
            main_q        <= main_d;
            skid_q        <= skid_d;
            out_valid_q   <= out_valid_d;
            in_ready_q    <= in_ready_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign illegal_cnt = illegal_cnt_q;
    assign {out_opcode, out_class, out_illegal, out_dest, out_op1,
            out_op2, out_shamt, out_imm, out_addr} = main_q;

endmodule
